mc_alu: RTL and testbench



---
 rtl/mc_alu.sv | 129 ++++++++++++
 tb/tb_mc_alu.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mc_alu.sv
// Multi-cycle ALU: registered single-cycle ops, bit-serial Hamming distance and optional shift-add multiply.
// Define MC_ALU_MUL_EN to build the multiplier (aluc=1000); otherwise that code returns 0 in one cycle.
module mc_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             z
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic             busy_q, done_q, z_q;
    logic [WIDTH-1:0] s_q, acc_q, work_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] res_d, acc_d;
    logic             mul_sel, iter_sel;
`ifdef MC_ALU_MUL_EN
    logic             mul_q;
    logic [WIDTH-1:0] mcand_q;
`endif

    always_comb begin
        res_d = '0;
        casez (aluc)
            4'b0000: res_d = a + b;
            4'b?100: res_d = a - b;
            4'b?001: res_d = a & b;
            4'b?101: res_d = a | b;
            4'b?010: res_d = a ^ b;
            4'b?110: res_d = a << 16;
            4'b0011: res_d = b << a[SHW-1:0];
            4'b0111: res_d = b >> a[SHW-1:0];
            4'b1111: res_d = $signed(b) >>> a[SHW-1:0];
            default: res_d = '0;
        endcase
    end

`ifdef MC_ALU_MUL_EN
    assign mul_sel = (aluc == 4'b1000);
`else
    assign mul_sel = 1'b0;
`endif
    assign iter_sel = (aluc == 4'b1011) || mul_sel;

    // mcand_q is pre-shifted each cycle, so it already carries the bit-index weight
    always_comb begin
`ifdef MC_ALU_MUL_EN
        if (mul_q)
            acc_d = work_q[0] ? acc_q + mcand_q : acc_q;
        else
            acc_d = acc_q + WIDTH'(work_q[0]);
`else
        acc_d = acc_q + WIDTH'(work_q[0]);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            z_q     <= 1'b1;
            acc_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
`ifdef MC_ALU_MUL_EN
            mul_q   <= 1'b0;
            mcand_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (!start) begin
                        state_q <= IDLE;
                    end else if (iter_sel) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        acc_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        work_q  <= mul_sel ? b : (a ^ b);
`ifdef MC_ALU_MUL_EN
                        mul_q   <= mul_sel;
                        mcand_q <= a;
`endif
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        s_q     <= res_d;
                        z_q     <= (res_d == '0);
                    end
                end
                RUN: begin
                    acc_q  <= acc_d;
                    work_q <= work_q >> 1;
                    cnt_q  <= cnt_q - CW'(1);
`ifdef MC_ALU_MUL_EN
                    mcand_q <= mcand_q << 1;
`endif
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        s_q     <= acc_d;
                        z_q     <= (acc_d == '0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign z    = z_q;
endmodule

// File: tb/tb_mc_alu.sv
// Directed bench for mc_alu (WIDTH=32) with hand-computed expected values.
module tb_mc_alu;
    logic        clock = 1'b0;
    logic        reset, start;
    logic [31:0] a, b, s;
    logic [3:0]  aluc;
    logic        busy, done, z;

    int n_total = 0;
    int n_bad   = 0;

    mc_alu #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .a(a), .b(b), .aluc(aluc),
        .busy(busy), .done(done), .s(s), .z(z)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue a single-cycle op and check the result in the cycle after the sampling edge.
    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_s);
        aluc = op; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".done"}, done, 1);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".s"}, s, exp_s);
        chk({tag, ".z"}, z, exp_s == 0);
    endtask

    // Start an iterative op; optionally scramble inputs during RUN. Returns done cycle and busy count.
    task automatic iter(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input bit scramble, output int cyc, output int nbusy, output int overlap);
        aluc = op; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1; nbusy = 0; overlap = 0;
        while (!done && cyc < 100) begin
            nbusy += int'(busy);
            if (busy && done) overlap++;
            if (scramble) begin
                a = $urandom; b = $urandom; start = cyc[0];
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        if (busy && done) overlap++;
    endtask

    initial begin
        int cyc, nbusy, overlap, npulse;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; aluc = '0;
        tick(); tick();
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.s", s, 0);
        chk("rst.z", z, 1);
        reset = 1'b0;
        tick();

        single("add", 4'b0000, 32'd5, 32'd7, 32'd12);
        tick();
        chk("add.done_drop", done, 0);
        single("sub", 4'b0100, 32'd9, 32'd9, 32'd0);
        single("sra", 4'b1111, 32'd4, 32'h8000_0000, 32'hF800_0000);
        single("srl", 4'b0111, 32'd4, 32'h8000_0000, 32'h0800_0000);
        single("sll", 4'b0011, 32'd31, 32'd1, 32'h8000_0000);
        single("lui", 4'b1110, 32'h0000_1234, 32'd0, 32'h1234_0000);
        single("and", 4'b1001, 32'h0F0F_00FF, 32'hFF00_0F0F, 32'h0F00_000F);
        single("sub_wrap", 4'b1100, 32'd0, 32'd1, 32'hFFFF_FFFF);
        tick();

        iter(4'b1011, 32'hFFFF_0000, 32'h0000_FFFF, 1'b1, cyc, nbusy, overlap);
        chk("ham.done_cycle", cyc, 33);
        chk("ham.busy_cycles", nbusy, 32);
        chk("ham.overlap", overlap, 0);
        chk("ham.s", s, 32);
        chk("ham.z", z, 0);
        tick();
        chk("ham.no_restart_busy", busy, 0);
        chk("ham.done_drop", done, 0);
        chk("ham.s_hold", s, 32);

        iter(4'b1011, 32'h1234_5678, 32'h1234_5678, 1'b0, cyc, nbusy, overlap);
        chk("ham0.done_cycle", cyc, 33);
        chk("ham0.s", s, 0);
        chk("ham0.z", z, 1);
        tick();

        // back-to-back: start held across XOR then OR
        aluc = 4'b0010; a = 32'h0000_F0F0; b = 32'h0000_FF00; start = 1'b1;
        tick();
        chk("b2b.xor_done", done, 1);
        chk("b2b.xor_s", s, 32'h0000_0FF0);
        aluc = 4'b0101; a = 32'h0000_F000; b = 32'h0000_000F;
        tick();
        start = 1'b0;
        chk("b2b.or_done", done, 1);
        chk("b2b.or_s", s, 32'h0000_F00F);
        tick();
        chk("b2b.done_drop", done, 0);

        // reset at cycle 10 of a HAM run
        aluc = 4'b1011; a = 32'hFFFF_FFFF; b = 32'h0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        chk("rstmid.busy_before", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid.busy", busy, 0);
        chk("rstmid.done", done, 0);
        chk("rstmid.s", s, 0);
        chk("rstmid.z", z, 1);
        npulse = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            npulse += int'(done);
        end
        chk("rstmid.no_done", npulse, 0);

`ifdef MC_ALU_MUL_EN
        iter(4'b1000, 32'h0001_0001, 32'h0001_0003, 1'b1, cyc, nbusy, overlap);
        chk("mul.done_cycle", cyc, 33);
        chk("mul.busy_cycles", nbusy, 32);
        chk("mul.s", s, 32'h0004_0003);
        chk("mul.z", z, 0);
`else
        single("add_pre", 4'b0000, 32'd1, 32'd2, 32'd3);
        single("mul_off", 4'b1000, 32'h0001_0001, 32'h0001_0003, 32'd0);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
